multicycle_control_unit: RTL and testbench

//  Multi-cycle successor to the single-cycle control decoder: FSM sequences FETCH/DECODE/EXEC/MEM/WB
//  per instruction, handshaking with instruction and data memories (ready-based, variable latency).

---
 rtl/mcu_pkg.sv | 65 ++++++
 rtl/mcu_imm_gen.sv | 22 ++
 rtl/multicycle_control_unit.sv | 167 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - opcodes, FSM state codes, ALU op codes and decode helpers for multicycle_control_unit
package mcu_pkg;

  localparam logic [6:0] OPC_R   = 7'b1110011;
  localparam logic [6:0] OPC_I   = 7'b0011111;
  localparam logic [6:0] OPC_LW  = 7'b1000011;
  localparam logic [6:0] OPC_SW  = 7'b1100011;
  localparam logic [6:0] OPC_BR  = 7'b1101011;
  localparam logic [6:0] OPC_LUI = 7'b0110000;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRA   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_PASSB = 4'b1000;

  // Unlisted R/I function codes and unknown opcodes fall back to ADD.
  function automatic logic [3:0] alu_decode(input logic [6:0] opc, input logic [2:0] f3,
                                            input logic [6:0] f7);
    logic [3:0] op;
    op = ALU_ADD;
    case (opc)
      OPC_R: begin
        case ({f3, f7})
          {3'b000, 7'b0000000}: op = ALU_AND;
          {3'b001, 7'b0000000}: op = ALU_ADD;
          {3'b001, 7'b0100000}: op = ALU_SUB;
          {3'b010, 7'b0000000}: op = ALU_OR;
          {3'b100, 7'b0000000}: op = ALU_XOR;
          {3'b101, 7'b0000000}: op = ALU_SRA;
          {3'b110, 7'b0000000}: op = ALU_SLL;
          {3'b111, 7'b0000000}: op = ALU_SLT;
          default:              op = ALU_ADD;
        endcase
      end
      OPC_I: begin
        case (f3)
          3'b001:  op = ALU_OR;
          3'b010:  op = ALU_XOR;
          default: op = ALU_ADD;
        endcase
      end
      OPC_BR:  op = ALU_SUB;
      OPC_LUI: op = ALU_PASSB;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic alu_src_decode(input logic [6:0] opc);
    return (opc == OPC_I) || (opc == OPC_LW) || (opc == OPC_SW) || (opc == OPC_LUI);
  endfunction

endpackage

// File: rtl/mcu_imm_gen.sv
// rtl/mcu_imm_gen.sv - combinational immediate extractor, sign-extends I/S/B/U immediates to XLEN
module mcu_imm_gen
  import mcu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_I, OPC_LW: imm = XLEN'(signed'(instr[31:20]));
      OPC_SW:        imm = XLEN'(signed'({instr[31:25], instr[11:7]}));
      OPC_BR:        imm = XLEN'(signed'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      OPC_LUI:       imm = XLEN'(signed'({instr[31:12], 12'b0}));
      default:       imm = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - FETCH/DECODE/EXEC/MEM/WB control FSM with ready handshakes
// MCU_ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP with sticky illegal_o instead of retiring as NOP
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_i,
  input  logic             if_ready_i,
  input  logic             mem_ready_i,
  input  logic             zero_i,
  input  logic             lt_i,
  output logic             if_req_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             pc_src_o,
  output logic             reg_we_o,
  output logic             alu_src_o,
  output logic [3:0]       alu_op_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             mem_to_reg_o,
  output logic [XLEN-1:0]  imm_ext_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instret_o
);

  logic [2:0]       state, state_nx;
  logic [31:0]      ir;
  logic [CNT_W-1:0] instret;
  logic             retire;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_lw, is_sw, is_br, goes_wb, taken;
  logic [3:0] dec_op;
  logic       dec_src;

  assign opc     = ir[6:0];
  assign f3      = ir[14:12];
  assign is_lw   = (opc == OPC_LW);
  assign is_sw   = (opc == OPC_SW);
  assign is_br   = (opc == OPC_BR);
  assign goes_wb = (opc == OPC_R) || (opc == OPC_I) || (opc == OPC_LUI);
  assign taken   = is_br && (((f3 == 3'b000) && zero_i) || ((f3 == 3'b001) && lt_i));
  assign dec_op  = alu_decode(opc, f3, ir[31:25]);
  assign dec_src = alu_src_decode(opc);

  mcu_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (ir),
    .imm   (imm_ext_o)
  );

  always_comb begin
    state_nx     = state;
    retire       = 1'b0;
    if_req_o     = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_src_o     = 1'b0;
    reg_we_o     = 1'b0;
    alu_src_o    = 1'b0;
    alu_op_o     = ALU_ADD;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_to_reg_o = 1'b0;
    case (state)
      ST_FETCH: begin
        if_req_o = 1'b1;
        if (if_ready_i) begin
          ir_we_o  = 1'b1;
          pc_we_o  = 1'b1;
          state_nx = ST_DECODE;
        end
      end
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC: begin
        alu_op_o     = dec_op;
        alu_src_o    = dec_src;
        mem_to_reg_o = is_lw;
        if (goes_wb) begin
          state_nx = ST_WB;
        end else if (is_lw || is_sw) begin
          state_nx = ST_MEM;
        end else if (is_br) begin
          pc_src_o = 1'b1;
          pc_we_o  = taken;
          retire   = 1'b1;
          state_nx = ST_FETCH;
        end else begin
`ifdef MCU_ILLEGAL_TRAP_EN
          state_nx = ST_TRAP;
`else
          retire   = 1'b1;
          state_nx = ST_FETCH;
`endif
        end
      end
      ST_MEM: begin
        alu_op_o     = dec_op;
        alu_src_o    = dec_src;
        mem_to_reg_o = is_lw;
        mem_req_o    = 1'b1;
        mem_we_o     = is_sw;
        if (mem_ready_i) begin
          retire   = is_sw;
          state_nx = is_sw ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        alu_op_o     = dec_op;
        alu_src_o    = dec_src;
        mem_to_reg_o = is_lw;
        reg_we_o     = 1'b1;
        retire       = 1'b1;
        state_nx     = ST_FETCH;
      end
      ST_TRAP: state_nx = ST_TRAP;
      default: state_nx = ST_FETCH;
    endcase
    // Outputs go quiet the moment reset asserts, even mid-handshake.
    if (!rst_n) begin
      retire       = 1'b0;
      if_req_o     = 1'b0;
      ir_we_o      = 1'b0;
      pc_we_o      = 1'b0;
      pc_src_o     = 1'b0;
      reg_we_o     = 1'b0;
      alu_src_o    = 1'b0;
      alu_op_o     = ALU_ADD;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_to_reg_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_FETCH;
      ir      <= '0;
      instret <= '0;
    end else begin
      state <= state_nx;
      if (ir_we_o) ir <= instr_i;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  assign instret_o = instret;

`ifdef MCU_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else if (state == ST_EXEC && state_nx == ST_TRAP) illegal_q <= 1'b1;
  end

  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench against an instruction-level schedule model
module tb_multicycle_control_unit;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_LUI = 5, C_UNK = 6;

  typedef struct packed {
    logic        if_req, ir_we, pc_we, pc_src, reg_we, alu_src;
    logic [3:0]  alu_op;
    logic        mem_req, mem_we, mem_to_reg, illegal;
    logic [31:0] imm;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr_i = '0;
  logic        if_ready_i = 1'b0, mem_ready_i = 1'b0, zero_i = 1'b0, lt_i = 1'b0;
  logic        if_req_o, ir_we_o, pc_we_o, pc_src_o, reg_we_o, alu_src_o;
  logic [3:0]  alu_op_o;
  logic        mem_req_o, mem_we_o, mem_to_reg_o, illegal_o;
  logic [31:0] imm_ext_o, instret_o;
  logic        d4_if_req, d4_ir_we, d4_pc_we, d4_pc_src, d4_reg_we, d4_alu_src;
  logic [3:0]  d4_alu_op;
  logic        d4_mem_req, d4_mem_we, d4_mem_to_reg, d4_illegal;
  logic [31:0] d4_imm;
  logic [3:0]  d4_instret;

  multicycle_control_unit #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .if_ready_i(if_ready_i),
    .mem_ready_i(mem_ready_i), .zero_i(zero_i), .lt_i(lt_i),
    .if_req_o(if_req_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o),
    .reg_we_o(reg_we_o), .alu_src_o(alu_src_o), .alu_op_o(alu_op_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_to_reg_o(mem_to_reg_o), .imm_ext_o(imm_ext_o),
    .illegal_o(illegal_o), .instret_o(instret_o)
  );

  multicycle_control_unit #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .if_ready_i(if_ready_i),
    .mem_ready_i(mem_ready_i), .zero_i(zero_i), .lt_i(lt_i),
    .if_req_o(d4_if_req), .ir_we_o(d4_ir_we), .pc_we_o(d4_pc_we), .pc_src_o(d4_pc_src),
    .reg_we_o(d4_reg_we), .alu_src_o(d4_alu_src), .alu_op_o(d4_alu_op), .mem_req_o(d4_mem_req),
    .mem_we_o(d4_mem_we), .mem_to_reg_o(d4_mem_to_reg), .imm_ext_o(d4_imm),
    .illegal_o(d4_illegal), .instret_o(d4_instret)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  exp_t        expq[$];
  exp_t        ce;
  logic [31:0] m_ir = '0, m_cnt = '0;
  logic        m_ill = 1'b0;
  int          force_z = -1;
  int          cyc, memreq_cycles, regwe_cycles;
  logic        snap_pcwe, snap_pcsrc, ex_pcwe, ex_pcsrc;
  logic [3:0]  snap_alu, ex_alu;
  logic [3:0]  rtab [8] = '{4'h2, 4'h0, 4'h3, 4'h0, 4'h4, 4'h5, 4'h6, 4'h7};
  logic [3:0]  itab [8] = '{4'h0, 4'h3, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int cls(input logic [31:0] ins);
    case (ins[6:0])
      7'b1110011: return C_R;
      7'b0011111: return C_I;
      7'b1000011: return C_LW;
      7'b1100011: return C_SW;
      7'b1101011: return C_BR;
      7'b0110000: return C_LUI;
      default:    return C_UNK;
    endcase
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    int v;
    v = 0;
    case (cls(ins))
      C_I, C_LW: begin v = int'(ins[31:20]); if (v >= 2048) v -= 4096; end
      C_SW: begin v = int'(ins[31:25]) * 32 + int'(ins[11:7]); if (v >= 2048) v -= 4096; end
      C_BR: begin
        v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      C_LUI: return {ins[31:12], 12'h000};
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [3:0] m_alu(input logic [31:0] ins);
    case (cls(ins))
      C_R: begin
        if (ins[31:25] == 7'b0) return rtab[ins[14:12]];
        if (ins[31:25] == 7'b0100000 && ins[14:12] == 3'b001) return 4'h1;
        return 4'h0;
      end
      C_I:     return itab[ins[14:12]];
      C_BR:    return 4'h1;
      C_LUI:   return 4'h8;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic m_src(input int c);
    return (c == C_I) || (c == C_LW) || (c == C_SW) || (c == C_LUI);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic exp_t base();
    exp_t e;
    e = '0;
    e.imm = m_imm(m_ir);
    e.cnt = m_cnt;
    e.illegal = m_ill;
    return e;
  endfunction

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      ce = expq.pop_front();
      chk("ctrl", {if_req_o, ir_we_o, pc_we_o, pc_src_o, reg_we_o, alu_src_o, alu_op_o,
                   mem_req_o, mem_we_o, mem_to_reg_o, illegal_o},
                  {ce.if_req, ce.ir_we, ce.pc_we, ce.pc_src, ce.reg_we, ce.alu_src, ce.alu_op,
                   ce.mem_req, ce.mem_we, ce.mem_to_reg, ce.illegal});
      chk("imm", imm_ext_o, ce.imm);
      chk("instret", instret_o, ce.cnt);
      chk("instret4", d4_instret, ce.cnt[3:0]);
    end
  end

  task automatic step(input exp_t e, input logic ifr, input logic memr, input logic z,
                      input logic l, input logic [31:0] ins);
    if_ready_i = ifr; mem_ready_i = memr; zero_i = z; lt_i = l; instr_i = ins;
    expq.push_back(e);
    #1;
    snap_pcwe = pc_we_o; snap_pcsrc = pc_src_o; snap_alu = alu_op_o;
    if (mem_req_o) memreq_cycles++;
    if (reg_we_o) regwe_cycles++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; if_ready_i = 1'b1; mem_ready_i = 1'b1; zero_i = 1'b0; lt_i = 1'b0;
    #1;
    chk("rst_ifreq", if_req_o, 1'b0);
    chk("rst_ctrl", {ir_we_o, pc_we_o, pc_src_o, reg_we_o, mem_req_o, mem_we_o, mem_to_reg_o}, 7'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; if_ready_i = 1'b0; mem_ready_i = 1'b0;
    m_cnt = '0; m_ir = '0; m_ill = 1'b0;
    #1;
    chk("rst_state", {if_req_o, illegal_o, reg_we_o}, 3'b100);
    chk("rst_instret", instret_o, 32'd0);
    chk("rst_imm", imm_ext_o, 32'd0);
  endtask

  task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input int abort_at);
    int   c;
    exp_t e;
    logic z, l, tk;
    c = cls(ins);
    cyc = 0; memreq_cycles = 0; regwe_cycles = 0;
    for (int k = 0; k < wf; k++) begin
      e = base(); e.if_req = 1'b1;
      step(e, 1'b0, rb(), rb(), rb(), $urandom);
    end
    e = base(); e.if_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    step(e, 1'b1, rb(), rb(), rb(), ins);
    m_ir = ins;
    e = base();
    step(e, rb(), rb(), rb(), rb(), $urandom);
    z = (force_z < 0) ? rb() : force_z[0];
    l = rb();
    tk = (ins[14:12] == 3'b000 && z) || (ins[14:12] == 3'b001 && l);
    e = base(); e.alu_op = m_alu(ins); e.alu_src = m_src(c); e.mem_to_reg = (c == C_LW);
    if (c == C_BR) begin e.pc_src = 1'b1; e.pc_we = tk; end
    step(e, rb(), rb(), z, l, $urandom);
    ex_pcwe = snap_pcwe; ex_pcsrc = snap_pcsrc; ex_alu = snap_alu;
    if (c == C_BR) begin m_cnt++; return; end
    if (c == C_UNK) begin
`ifdef MCU_ILLEGAL_TRAP_EN
      m_ill = 1'b1;
      for (int k = 0; k < 3; k++) begin
        e = base();
        step(e, rb(), rb(), rb(), rb(), $urandom);
      end
`else
      m_cnt++;
`endif
      return;
    end
    if (c == C_LW || c == C_SW) begin
      for (int k = 0; k <= wm; k++) begin
        if (k == abort_at) begin do_reset(); return; end
        e = base(); e.alu_op = m_alu(ins); e.alu_src = 1'b1; e.mem_to_reg = (c == C_LW);
        e.mem_req = 1'b1; e.mem_we = (c == C_SW);
        step(e, rb(), (k == wm), rb(), rb(), $urandom);
      end
      if (c == C_SW) begin m_cnt++; return; end
    end
    e = base(); e.alu_op = m_alu(ins); e.alu_src = m_src(c); e.mem_to_reg = (c == C_LW);
    e.reg_we = 1'b1;
    step(e, rb(), rb(), rb(), rb(), $urandom);
    m_cnt++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 12);
    case (k)
      0, 1, 10: begin
        r[6:0] = 7'b1110011;
        case ($urandom_range(0, 3))
          0, 3:    r[31:25] = 7'b0;
          1:       r[31:25] = 7'b0100000;
          default: ;
        endcase
      end
      2, 3, 11: r[6:0] = 7'b0011111;
      4:        r[6:0] = 7'b1000011;
      5:        r[6:0] = 7'b1100011;
      6, 7:     begin r[6:0] = 7'b1101011; r[14:13] = (rb() ? 2'b00 : r[14:13]); end
      8, 12:    r[6:0] = 7'b0110000;
      default:  if (cls(r) != C_UNK) r[6:0] = 7'b0000000;
    endcase
    return r;
  endfunction

  logic [31:0] ins_add, ins_lw, ins_beq, ins_lui, ins_sw, ri;
  int          wm_r;

  initial begin
    ins_add = {7'b0000000, 5'd2, 5'd1, 3'b001, 5'd3, 7'b1110011};
    ins_lw  = {12'hFFC, 5'd5, 3'b010, 5'd6, 7'b1000011};
    ins_beq = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'b01000, 7'b1101011};
    ins_lui = {20'h12345, 5'd7, 7'b0110000};
    ins_sw  = {7'b0000000, 5'd2, 5'd1, 3'b010, 5'd4, 7'b1100011};
    #1;
    do_reset();

    run_instr(ins_add, 0, 0, -1);
    chk("add_cycles", cyc, 4);
    chk("add_aluop", ex_alu, 4'b0000);
    chk("add_regwe", regwe_cycles, 1);
    chk("add_instret", instret_o, 32'd1);

    run_instr(ins_lw, 0, 3, -1);
    chk("lw_imm", imm_ext_o, 32'hFFFF_FFFC);
    chk("lw_memreq", memreq_cycles, 4);
    chk("lw_cycles", cyc, 8);
    chk("lw_instret", instret_o, 32'd2);

    force_z = 1;
    run_instr(ins_beq, 0, 0, -1);
    chk("beq_t_pc", {ex_pcwe, ex_pcsrc}, 2'b11);
    chk("beq_t_cycles", cyc, 3);
    chk("beq_t_regwe", regwe_cycles, 0);
    force_z = 0;
    run_instr(ins_beq, 0, 0, -1);
    chk("beq_nt_pc", {ex_pcwe, ex_pcsrc}, 2'b01);
    force_z = -1;

    run_instr(ins_lui, 0, 0, -1);
    chk("lui_imm", imm_ext_o, 32'h1234_5000);
    chk("lui_aluop", ex_alu, 4'b1000);
    chk("lui_regwe", regwe_cycles, 1);

    run_instr(32'h0000_0000, 0, 0, -1);
`ifdef MCU_ILLEGAL_TRAP_EN
    chk("trap_illegal", illegal_o, 1'b1);
    chk("trap_ifreq", if_req_o, 1'b0);
    chk("trap_instret", instret_o, 32'd5);
`else
    chk("nop_instret", instret_o, 32'd6);
    chk("nop_ifreq", if_req_o, 1'b1);
    chk("nop_illegal", illegal_o, 1'b0);
`endif

    do_reset();
    run_instr(ins_sw, 0, 3, 1);
    chk("abort_instret", instret_o, 32'd0);
    chk("abort_instret4", d4_instret, 4'd0);

    for (int i = 0; i < 15; i++) run_instr(ins_add, $urandom_range(0, 1), 0, -1);
    chk("wrap4_15", d4_instret, 4'hF);
    run_instr(ins_add, 0, 0, -1);
    chk("wrap4_0", d4_instret, 4'h0);
    chk("wrap32_16", instret_o, 32'd16);

    for (int i = 0; i < 400; i++) begin
      ri = rand_instr();
      wm_r = $urandom_range(0, 3);
      run_instr(ri, $urandom_range(0, 2), wm_r,
                ($urandom_range(0, 29) == 0) ? $urandom_range(0, wm_r) : -1);
      if (m_ill) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
